subservient_uart_loader: RTL and testbench

//  UART firmware loader that drives the subservient debug Wishbone port.
//  It holds the core in debug mode from reset and receives a length-prefixed, checksummed

---
 rtl/subservient_uart_loader.sv | 169 ++++++++++++++++
 tb/tb_subservient_uart_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/subservient_uart_loader.sv
// UART firmware loader: receives a length-prefixed, checksummed image and writes it
// word by word over the subservient debug Wishbone port, releasing debug mode on success.
module subservient_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int memsize      = 8192
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_uart_rx,
  output logic        o_debug_mode,
  output logic [31:0] o_wb_dbg_adr,
  output logic [31:0] o_wb_dbg_dat,
  output logic [3:0]  o_wb_dbg_sel,
  output logic        o_wb_dbg_we,
  output logic        o_wb_dbg_stb,
  input  logic        i_wb_dbg_ack,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  assign o_wb_dbg_sel = 4'hF;
  assign o_wb_dbg_we  = 1'b1;

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  rx_st_t         rx_st;
  logic           rx_s1, rx_s, rx_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     bitn;
  logic [7:0]     rx_data;
  logic           rx_valid, rx_ferr;

  always_ff @(posedge i_clk) begin
    rx_valid <= 1'b0;
    rx_ferr  <= 1'b0;
    if (i_rst) begin
      rx_s1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= R_IDLE;
      cnt     <= '0;
      bitn    <= '0;
      rx_data <= '0;
    end else begin
      rx_s1   <= i_uart_rx;
      rx_s    <= rx_s1;
      rx_prev <= rx_s;
      case (rx_st)
        R_IDLE:
          if (rx_prev && !rx_s) begin
            rx_st <= R_START;
            cnt   <= '0;
          end
        R_START:
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            bitn  <= '0;
            // a line that is high again mid start bit was only a glitch
            rx_st <= rx_s ? R_IDLE : R_DATA;
          end else cnt <= cnt + 1'b1;
        R_DATA:
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            rx_data <= {rx_s, rx_data[7:1]};
            if (bitn == 3'd7) rx_st <= R_STOP;
            else bitn <= bitn + 1'b1;
          end else cnt <= cnt + 1'b1;
        R_STOP:
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            rx_st    <= R_IDLE;
            rx_valid <= rx_s;
            rx_ferr  <= !rx_s;
          end else cnt <= cnt + 1'b1;
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // ---------------- frame FSM + Wishbone stage ----------------
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_CHK, S_DONE, S_ERR} st_t;
  st_t         st;
  logic [31:0] len, k, word, nword, len_n;
  logic [1:0]  hidx, lane;
  logic [7:0]  sum, csum;
  logic        last, handoff;

  always_comb begin
    lane    = k[1:0];
    nword   = (lane == 2'd0) ? 32'(rx_data) : (word | (32'(rx_data) << {lane, 3'b000}));
    last    = (k == len - 32'd1);
    handoff = (lane == 2'd3) || last;
    len_n   = {rx_data, len[31:8]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st           <= S_LEN;
      len          <= '0;
      k            <= '0;
      hidx         <= '0;
      word         <= '0;
      sum          <= '0;
      csum         <= '0;
      o_wb_dbg_stb <= 1'b0;
      o_wb_dbg_adr <= '0;
      o_wb_dbg_dat <= '0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_err_code   <= 2'd0;
      o_debug_mode <= 1'b1;
    end else begin
      if (o_wb_dbg_stb && i_wb_dbg_ack) o_wb_dbg_stb <= 1'b0;
      case (st)
        S_LEN:
          if (rx_ferr) begin
            st <= S_ERR; o_err <= 1'b1; o_err_code <= 2'd0;
          end else if (rx_valid) begin
            len  <= len_n;
            hidx <= hidx + 1'b1;
            if (hidx == 2'd3) begin
              if (len_n > 32'(memsize)) begin
                st <= S_ERR; o_err <= 1'b1; o_err_code <= 2'd1;
              end else st <= (len_n == 32'd0) ? S_CSUM : S_DATA;
            end
          end
        S_DATA:
          if (rx_ferr) begin
            st <= S_ERR; o_err <= 1'b1; o_err_code <= 2'd0;
          end else if (rx_valid) begin
            word <= nword;
            sum  <= sum + rx_data;
            k    <= k + 32'd1;
            if (last) st <= S_CSUM;
            if (handoff) begin
              // single word of buffering: a second word while one is pending is an overrun
              if (o_wb_dbg_stb) begin
                st <= S_ERR; o_err <= 1'b1; o_err_code <= 2'd2;
              end else begin
                o_wb_dbg_stb <= 1'b1;
                o_wb_dbg_adr <= {k[31:2], 2'b00};
                o_wb_dbg_dat <= nword;
              end
            end
          end
        S_CSUM:
          if (rx_ferr) begin
            st <= S_ERR; o_err <= 1'b1; o_err_code <= 2'd0;
          end else if (rx_valid) begin
            csum <= rx_data;
            st   <= S_CHK;
          end
        S_CHK:
          if (!o_wb_dbg_stb) begin
            if (csum == sum) begin
              st <= S_DONE; o_done <= 1'b1; o_debug_mode <= 1'b0;
            end else begin
              st <= S_ERR; o_err <= 1'b1; o_err_code <= 2'd3;
            end
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_subservient_uart_loader.sv
// Scoreboarded bench: frames are modelled up front into expected writes/outcome,
// a Wishbone responder process pops and compares each acknowledged write.
module tb_subservient_uart_loader;
  localparam int CPB = 16;
  localparam int MEM = 8192;

  logic        i_clk = 0, i_rst = 1, i_uart_rx = 1, i_wb_dbg_ack = 0;
  logic        o_debug_mode, o_wb_dbg_we, o_wb_dbg_stb, o_done, o_err;
  logic [31:0] o_wb_dbg_adr, o_wb_dbg_dat;
  logic [3:0]  o_wb_dbg_sel;
  logic [1:0]  o_err_code;

  subservient_uart_loader #(.CLKS_PER_BIT(CPB), .memsize(MEM)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_uart_rx(i_uart_rx),
    .o_debug_mode(o_debug_mode), .o_wb_dbg_adr(o_wb_dbg_adr), .o_wb_dbg_dat(o_wb_dbg_dat),
    .o_wb_dbg_sel(o_wb_dbg_sel), .o_wb_dbg_we(o_wb_dbg_we), .o_wb_dbg_stb(o_wb_dbg_stb),
    .i_wb_dbg_ack(i_wb_dbg_ack), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code));

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;
  wr_t        exp_q[$];
  logic [7:0] img_q[$];
  int errs = 0, checks = 0;
  int ack_dly = 2;
  bit ack_hold = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wishbone responder + scoreboard monitor
  initial begin
    int dcnt = 0;
    wr_t e;
    forever begin
      @(negedge i_clk);
      if (o_wb_dbg_stb && !ack_hold && !i_rst) begin
        if (dcnt < ack_dly) dcnt++;
        else begin
          i_wb_dbg_ack = 1;
          if (exp_q.size() == 0) begin
            errs++; checks++;
            $display("FAIL unexpected_write: got adr %h dat %h expected none", o_wb_dbg_adr, o_wb_dbg_dat);
          end else begin
            e = exp_q.pop_front();
            chk("wb_adr", o_wb_dbg_adr, e.adr);
            chk("wb_dat", o_wb_dbg_dat, e.dat);
            chk("wb_sel_we", {27'd0, o_wb_dbg_sel, o_wb_dbg_we}, {27'd0, 4'hF, 1'b1});
          end
          @(negedge i_clk);
          i_wb_dbg_ack = 0;
          dcnt = 0;
          chk("stb_drop_after_ack", {31'd0, o_wb_dbg_stb}, 32'd0);
        end
      end else dcnt = 0;
    end
  end

  initial begin
    repeat (95000) @(posedge i_clk);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    i_rst = 1; i_uart_rx = 1; ack_hold = 0;
    repeat (3) @(negedge i_clk);
    exp_q.delete();
    i_rst = 0;
    @(negedge i_clk);
  endtask

  task automatic uart_byte(input logic [7:0] b, input logic stop);
    i_uart_rx = 0; repeat (CPB) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin i_uart_rx = b[i]; repeat (CPB) @(negedge i_clk); end
    i_uart_rx = stop; repeat (CPB) @(negedge i_clk);
    i_uart_rx = 1; repeat (2 * CPB) @(negedge i_clk);
  endtask

  task automatic send_len(input logic [31:0] l);
    for (int i = 0; i < 4; i++) uart_byte(l[8*i +: 8], 1'b1);
  endtask

  // Model + drive one frame whose image is img_q. bad>=0 corrupts that image byte's stop bit.
  task automatic send_frame(input string name, input logic [31:0] lenf, input logic [7:0] c,
                            input int bad, input bit hold, input int dly);
    int n = img_q.size();
    logic [7:0] s = 0;
    bit e_done = 0, e_err = 0;
    logic [1:0] e_code = 0;
    wr_t w;
    ack_dly = dly; ack_hold = hold;
    if (lenf > MEM) begin
      e_err = 1; e_code = 1;
    end else begin
      foreach (img_q[i]) s += img_q[i];
      for (int wi = 0; wi * 4 < n; wi++) begin
        int lasti = (wi * 4 + 3 < n) ? wi * 4 + 3 : n - 1;
        w.adr = 32'(wi * 4); w.dat = 0;
        for (int j = wi * 4; j <= lasti; j++) w.dat |= 32'(img_q[j]) << (8 * (j % 4));
        if ((bad < 0 || lasti < bad) && (!hold || wi == 0)) exp_q.push_back(w);
      end
      if (bad >= 0)      begin e_err = 1; e_code = 0; end
      else if (hold)     begin e_err = 1; e_code = 2; end
      else if (c != s)   begin e_err = 1; e_code = 3; end
      else e_done = 1;
    end
    send_len(lenf);
    if (lenf <= MEM) begin
      for (int i = 0; i < n; i++) begin
        uart_byte(img_q[i], i != bad);
        if (i == bad) break;
      end
      if (bad < 0) uart_byte(c, 1'b1);
    end
    for (int i = 0; i < 3000 && !(o_done || o_err); i++) @(negedge i_clk);
    chk({name, "_finished"}, {31'd0, o_done | o_err}, 32'd1);
    if (hold) begin
      repeat (50 * CPB) @(negedge i_clk);
      ack_hold = 0;
    end
    repeat (40) @(negedge i_clk);
    chk({name, "_done"}, {31'd0, o_done}, {31'd0, e_done});
    chk({name, "_err"}, {31'd0, o_err}, {31'd0, e_err});
    if (e_err) chk({name, "_err_code"}, {30'd0, o_err_code}, {30'd0, e_code});
    chk({name, "_debug_mode"}, {31'd0, o_debug_mode}, {31'd0, !e_done});
    chk({name, "_pending_writes"}, exp_q.size(), 0);
    chk({name, "_stb_idle"}, {31'd0, o_wb_dbg_stb}, 32'd0);
  endtask

  initial begin
    do_reset();
    chk("rst_debug_mode", {31'd0, o_debug_mode}, 32'd1);
    chk("rst_stb", {31'd0, o_wb_dbg_stb}, 32'd0);
    chk("rst_adr", o_wb_dbg_adr, 32'd0);
    chk("rst_dat", o_wb_dbg_dat, 32'd0);
    chk("rst_sel_we", {27'd0, o_wb_dbg_sel, o_wb_dbg_we}, {27'd0, 4'hF, 1'b1});
    chk("rst_flags", {29'd0, o_done, o_err, o_err_code[0] | o_err_code[1]}, 32'd0);

    img_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h01, 8'h00, 8'h00};
    send_frame("l8", 32'd8, 8'h4B, -1, 0, 2);

    do_reset();
    img_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame("l5", 32'd5, 8'hFF, -1, 0, 0);

    do_reset();
    send_frame("bad_csum", 32'd5, 8'h00, -1, 0, 3);

    do_reset();
    img_q.delete();
    send_frame("too_long", 32'h00002001, 8'h00, -1, 0, 1);

    do_reset();
    send_frame("len_zero", 32'd0, 8'h00, -1, 0, 1);

    do_reset();
    img_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    send_frame("framing", 32'd6, 8'h00, 1, 0, 1);

    // short low glitch on the idle line must not be taken as a byte
    do_reset();
    i_uart_rx = 0; repeat (CPB / 4) @(negedge i_clk);
    i_uart_rx = 1; repeat (3 * CPB) @(negedge i_clk);
    img_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame("glitch", 32'd5, 8'hFF, -1, 0, 1);

    do_reset();
    img_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame("overrun", 32'd8, 8'h24, -1, 1, 0);

    // reset while a write is pending mid-DATA, then a clean reload without extra reset
    do_reset();
    ack_hold = 1;
    send_len(32'd8);
    for (int i = 0; i < 4; i++) uart_byte(8'(i + 1), 1'b1);
    chk("mid_stb_pending", {31'd0, o_wb_dbg_stb}, 32'd1);
    i_rst = 1;
    @(negedge i_clk);
    chk("mid_rst_stb", {31'd0, o_wb_dbg_stb}, 32'd0);
    i_rst = 0; ack_hold = 0; exp_q.delete();
    @(negedge i_clk);
    img_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame("after_rst", 32'd5, 8'hFF, -1, 0, 2);

    for (int t = 0; t < 4; t++) begin
      int n = $urandom_range(1, 11);
      logic [7:0] s = 0;
      do_reset();
      img_q.delete();
      for (int i = 0; i < n; i++) begin
        img_q.push_back(8'($urandom));
        s += img_q[i];
      end
      if ($urandom_range(0, 3) == 0) s = s ^ 8'h5A;
      send_frame($sformatf("rand%0d", t), 32'(n), s, -1, 0, $urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
